adc_deser_rx: RTL and testbench

- Receive-side deserializer for the 4-lane GPAC serial ADC link. It sits in the FPGA readout path, clocked by the ADC bit clock (DCO).
- Frames on the FCO rising edge, shifts in 14 bits MSB-first per lane, and presents parallel 14-bit samples with a VALID strobe.
- Tracks frame alignment and flags framing errors, so downstream FIFO/readout logic only sees samples from a locked link.

---
 rtl/adc_deser_pkg.sv | 25 ++
 rtl/adc_deser_lane.sv | 53 +++++
 rtl/adc_deser_rx.sv | 150 +++++++++++++++
 tb/tb_adc_deser_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_deser_pkg.sv
// Shared definitions for the GPAC ADC receive deserializer:
// framing state encoding, default link geometry and a width helper.
package adc_deser_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int ADC_BITS      = 14;
    localparam int ADC_FRAME_LEN = 16;
    localparam int ADC_NCH       = 4;

    // Smallest width able to hold values 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/adc_deser_lane.sv
// One serial lane of the ADC deserializer: MSB-first shift register plus an
// output word register loaded when the framer reports a complete, accepted word.
// Build option ADC_TWOS_COMP_EN: invert the sample MSB at latch time, turning
// offset-binary into two's complement without extra latency.
module adc_deser_lane
    import adc_deser_pkg::*;
#(
    parameter int BITS = ADC_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cap_en,
    input  logic            latch_en,
    input  logic            din,
    output logic [BITS-1:0] word_out
);

    // Only BITS-1 history bits are needed: the final bit arrives with latch_en.
    logic [BITS-2:0] shift_q, shift_d;
    logic [BITS-1:0] word_q, word_d;
    logic [BITS-1:0] next_word;

    // Shift in the current lane bit and form the candidate output word.
    always_comb begin
        next_word = {shift_q, din};
        shift_d   = shift_q;
        word_d    = word_q;
        if (cap_en) begin
            shift_d = next_word[BITS-2:0];
        end
        if (latch_en) begin
`ifdef ADC_TWOS_COMP_EN
            word_d = next_word ^ {1'b1, {(BITS-1){1'b0}}};
`else
            word_d = next_word;
`endif
        end
    end

    // Lane registers; reset clears both the partial and the presented word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            word_q  <= '0;
        end else begin
            shift_q <= shift_d;
            word_q  <= word_d;
        end
    end

    assign word_out = word_q;

endmodule

// File: rtl/adc_deser_rx.sv
// Receive-side deserializer for the 4-lane GPAC serial ADC link, clocked by DCO.
// Frames on FCO rising edges, tracks frame alignment (LOCKED), flags early and
// missing frame edges (FRAME_ERR) and only presents words that started while locked.
// Build option ADC_TWOS_COMP_EN (handled in the lanes): two's complement output.
module adc_deser_rx
    import adc_deser_pkg::*;
#(
    parameter int NCH       = ADC_NCH,
    parameter int BITS      = ADC_BITS,
    parameter int FRAME_LEN = ADC_FRAME_LEN,
    parameter int LOCK_CNT  = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                ADC_FCO,
    input  logic [NCH-1:0]      ADC_DATA,
    output logic [NCH*BITS-1:0] DATA_OUT,
    output logic                VALID,
    output logic                LOCKED,
    output logic                FRAME_ERR
);

    localparam int FCW = clog2(FRAME_LEN + 2);
    localparam int BCW = clog2(BITS + 1);
    localparam int GCW = clog2(LOCK_CNT + 1);

    state_e         state_q, state_d;
    logic           fco_q, fco_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0] good_cnt_q, good_cnt_d;
    logic           locked_q, locked_d;
    logic           word_ok_q, word_ok_d;
    logic           valid_q, valid_d;
    logic           frame_err_q, frame_err_d;
    logic           rise;
    logic           cap_en;
    logic           latch_en;

    // Framing FSM: edge classification, bit/frame counting and lock tracking.
    always_comb begin
        fco_d       = ADC_FCO;
        rise        = ADC_FCO & ~fco_q;
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        good_cnt_d  = good_cnt_q;
        locked_d    = locked_q;
        word_ok_d   = word_ok_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        cap_en      = 1'b0;
        latch_en    = 1'b0;

        if (!EN) begin
            // Disable is a quiet resync: no error, partial word dropped.
            state_d     = SYNC;
            frame_cnt_d = '0;
            bit_cnt_d   = '0;
            good_cnt_d  = '0;
            locked_d    = 1'b0;
            word_ok_d   = 1'b0;
        end else if (rise) begin
            // Every accepted rise restarts a word; this cycle carries the MSB.
            state_d     = SHIFT;
            cap_en      = 1'b1;
            bit_cnt_d   = BCW'(1);
            frame_cnt_d = FCW'(1);
            if (state_q == SYNC) begin
                good_cnt_d = GCW'(1);
                locked_d   = (good_cnt_d == GCW'(LOCK_CNT));
            end else if (frame_cnt_q == FCW'(FRAME_LEN)) begin
                good_cnt_d = (good_cnt_q >= GCW'(LOCK_CNT)) ? good_cnt_q
                                                             : good_cnt_q + GCW'(1);
                locked_d   = locked_q | (good_cnt_d == GCW'(LOCK_CNT));
            end else begin
                // Early edge: realign to it, which also discards the word in flight.
                frame_err_d = 1'b1;
                good_cnt_d  = GCW'(1);
                locked_d    = 1'b0;
            end
            // A word is delivered only if the link is locked as of its start edge.
            word_ok_d = locked_d;
        end else if (state_q != SYNC) begin
            if (frame_cnt_q == FCW'(FRAME_LEN)) begin
                // Missing edge: the expected rise did not come.
                frame_err_d = 1'b1;
                state_d     = SYNC;
                frame_cnt_d = '0;
                bit_cnt_d   = '0;
                good_cnt_d  = '0;
                locked_d    = 1'b0;
                word_ok_d   = 1'b0;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
                if (state_q == SHIFT) begin
                    cap_en    = 1'b1;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(BITS - 1)) begin
                        state_d  = GAP;
                        latch_en = word_ok_q;
                        valid_d  = word_ok_q;
                    end
                end
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= SYNC;
            fco_q       <= 1'b0;
            frame_cnt_q <= '0;
            bit_cnt_q   <= '0;
            good_cnt_q  <= '0;
            locked_q    <= 1'b0;
            word_ok_q   <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fco_q       <= fco_d;
            frame_cnt_q <= frame_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            good_cnt_q  <= good_cnt_d;
            locked_q    <= locked_d;
            word_ok_q   <= word_ok_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        adc_deser_lane #(.BITS(BITS)) u_lane (
            .clk      (CLK),
            .rst_n    (RST_N),
            .cap_en   (cap_en),
            .latch_en (latch_en),
            .din      (ADC_DATA[k]),
            .word_out (DATA_OUT[k*BITS +: BITS])
        );
    end

    assign VALID     = valid_q;
    assign LOCKED    = locked_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_adc_deser_rx.sv
// Scoreboard bench for adc_deser_rx: a frame-level ADC model drives FCO/DATA/EN,
// an event-level reference model queues expected words and error pulses, and a
// monitor compares DUT outputs one time unit after every rising clock edge.
module tb_adc_deser_rx;

    localparam int NCH       = 4;
    localparam int BITS      = 14;
    localparam int FRAME_LEN = 16;
    localparam int LOCK_CNT  = 4;
    localparam int W         = NCH * BITS;
    localparam int MAXC      = 8192;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           EN;
    logic           ADC_FCO;
    logic [NCH-1:0] ADC_DATA;
    logic [W-1:0]   DATA_OUT;
    logic           VALID;
    logic           LOCKED;
    logic           FRAME_ERR;

    adc_deser_rx #(
        .NCH(NCH), .BITS(BITS), .FRAME_LEN(FRAME_LEN), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .ADC_FCO(ADC_FCO), .ADC_DATA(ADC_DATA),
        .DATA_OUT(DATA_OUT), .VALID(VALID), .LOCKED(LOCKED), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;
    int cur_c  = -1;
    bit mon_en = 1'b0;

    // Reference model state (event level: times of rises, counts of good frames).
    typedef struct { int t; logic [W-1:0] d; } word_t;
    word_t          exp_words[$];
    int             exp_errs[$];
    logic [NCH-1:0] hist [0:MAXC-1];
    logic [W-1:0]   last_out;
    int             m_last_rise;
    bit             m_sync, m_locked, m_prev_fco, m_pend;
    int             m_good, m_pend_start;

    function automatic void chk_bit(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %b want %b", name, cur_c + 1, act, exp);
        end
    endfunction

    function automatic void chk_word(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h want %h", name, cur_c + 1, act, exp);
        end
    endfunction

    function automatic void model_reset();
        exp_words.delete();
        exp_errs.delete();
        last_out    = '0;
        m_last_rise = 0;
        m_sync      = 1'b1;
        m_locked    = 1'b0;
        m_prev_fco  = 1'b0;
        m_pend      = 1'b0;
        m_good      = 0;
        m_pend_start = 0;
    endfunction

    // Apply the link rules to input cycle c; outputs due at time c+1 onwards.
    function automatic void model_step(int c, bit fco, bit en, logic [NCH-1:0] d);
        bit    rise;
        bit    err;
        word_t w;
        hist[c]    = d;
        rise       = fco && !m_prev_fco;
        m_prev_fco = fco;
        err        = 1'b0;
        if (!en) begin
            m_sync = 1'b1; m_good = 0; m_locked = 1'b0; m_pend = 1'b0;
        end else if (rise) begin
            if (m_sync) m_good = 1;
            else if (c - m_last_rise == FRAME_LEN) m_good = (m_good < LOCK_CNT) ? m_good + 1 : LOCK_CNT;
            else begin
                err = 1'b1;
                exp_errs.push_back(c + 1);
                m_good   = 1;
                m_locked = 1'b0;
            end
            if (!err && m_good == LOCK_CNT) m_locked = 1'b1;
            m_sync       = 1'b0;
            m_last_rise  = c;
            m_pend       = m_locked;
            m_pend_start = c;
        end else if (!m_sync && c - m_last_rise == FRAME_LEN) begin
            exp_errs.push_back(c + 1);
            m_sync = 1'b1; m_good = 0; m_locked = 1'b0; m_pend = 1'b0;
        end else if (m_pend && c == m_pend_start + BITS - 1) begin
            w.t = c + 1;
            w.d = '0;
            for (int k = 0; k < NCH; k++) begin
                for (int i = 0; i < BITS; i++) w.d[k*BITS + BITS-1-i] = hist[m_pend_start + i][k];
`ifdef ADC_TWOS_COMP_EN
                w.d[k*BITS + BITS-1] = ~w.d[k*BITS + BITS-1];
`endif
            end
            exp_words.push_back(w);
            m_pend = 1'b0;
        end
    endfunction

    task automatic drive_cycle(input bit fco, input bit en, input logic [NCH-1:0] d);
        @(negedge CLK);
        cur_c++;
        ADC_FCO  = fco;
        EN       = en;
        ADC_DATA = d;
        model_step(cur_c, fco, en, d);
        mon_en = 1'b1;
    endtask

    // One FCO period of the ADC: FCO high for the first half, MSB-first data, random padding.
    task automatic send_frame(input int len, input logic [W-1:0] w, input int off_s, input int off_n);
        for (int i = 0; i < len; i++) begin
            logic [NCH-1:0] d;
            for (int k = 0; k < NCH; k++) d[k] = (i < BITS) ? w[k*BITS + BITS-1-i] : 1'($urandom);
            drive_cycle(i < 8 && i < len / 2 + 1 && i < len - 1, !(i >= off_s && i < off_s + off_n), d);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        return W'({$urandom, $urandom});
    endfunction

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) send_frame(FRAME_LEN, rand_word(), -1, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        mon_en  = 1'b0;
        RST_N   = 1'b0;
        ADC_FCO = 1'b0;
        EN      = 1'b1;
        #1;
        chk_word("rst_data_out", DATA_OUT, '0);
        chk_bit("rst_valid", VALID, 1'b0);
        chk_bit("rst_locked", LOCKED, 1'b0);
        chk_bit("rst_frame_err", FRAME_ERR, 1'b0);
        repeat (3) @(negedge CLK);
        model_reset();
        RST_N = 1'b1;
    endtask

    // Monitor: pop expected events when due and compare all outputs every cycle.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (mon_en) begin
                int t;
                bit exp_v, exp_e;
                t = cur_c + 1;
                while (exp_words.size() > 0 && exp_words[0].t < t) begin
                    chk_word("valid_time", W'(t), W'(exp_words[0].t));
                    void'(exp_words.pop_front());
                end
                while (exp_errs.size() > 0 && exp_errs[0] < t) begin
                    chk_word("frame_err_time", W'(t), W'(exp_errs[0]));
                    void'(exp_errs.pop_front());
                end
                exp_v = (exp_words.size() > 0 && exp_words[0].t == t);
                exp_e = (exp_errs.size() > 0 && exp_errs[0] == t);
                if (exp_v) last_out = exp_words.pop_front().d;
                if (exp_e) void'(exp_errs.pop_front());
                chk_bit("valid", VALID, exp_v);
                chk_bit("frame_err", FRAME_ERR, exp_e);
                chk_bit("locked", LOCKED, m_locked);
                chk_word("data_out", DATA_OUT, last_out);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N    = 1'b0;
        EN       = 1'b1;
        ADC_FCO  = 1'b0;
        ADC_DATA = '0;
        model_reset();
        do_reset();

        // Lock and fixed data, then random locked frames.
        for (int i = 0; i < 8; i++) send_frame(FRAME_LEN, {14'h0001, 14'h3FFF, 14'h0ABC, 14'h1234}, -1, 0);
        frames(6);

        // Early edge 9 cycles after a good edge, then re-lock.
        send_frame(9, rand_word(), -1, 0);
        frames(7);

        // Missing edge: one frame with FCO held low.
        send_frame(2 * FRAME_LEN, rand_word(), -1, 0);
        frames(7);

        // EN dropped for 5 cycles mid-frame.
        send_frame(FRAME_LEN, rand_word(), 5, 5);
        frames(7);

        // Reset asserted mid-frame (after bit 7 has been shifted).
        send_frame(7, rand_word(), -1, 0);
        do_reset();
        frames(6);

        // MSB boundary samples on channel 0.
        send_frame(FRAME_LEN, {rand_word() >> BITS, 14'h2000}, -1, 0);
        send_frame(FRAME_LEN, {rand_word() >> BITS, 14'h0000}, -1, 0);
        send_frame(FRAME_LEN, {rand_word() >> BITS, 14'h3FFF}, -1, 0);

        // Random frame lengths: mostly nominal, some early, some long.
        for (int i = 0; i < 40; i++) begin
            int r, len;
            r   = $urandom_range(0, 9);
            len = (r == 0) ? $urandom_range(10, 15) : (r == 1) ? $urandom_range(18, 24) : FRAME_LEN;
            send_frame(len, rand_word(), -1, 0);
        end
        frames(6);

        // Idle tail lets the final missing-edge error and any word drain.
        for (int i = 0; i < 24; i++) drive_cycle(1'b0, 1'b1, NCH'($urandom));
        @(posedge CLK);
        #2;
        mon_en = 1'b0;
        chk_word("words_left", W'(exp_words.size()), '0);
        chk_word("errs_left", W'(exp_errs.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
